// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage.
package decode_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_opcode_t;

endpackage

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: operand selection with forwarding, load-use
// bubble insertion, valid/ready handshake on both sides, flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_FWD  = 2,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [31:0]             i_instruction,
  output logic [4:0]              o_rs1_id,
  output logic [4:0]              o_rs2_id,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic [XLEN-1:0]         i_rs2_data,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [NUM_FWD*5-1:0]    i_fwd_rd_id,
  input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
  input  logic                    i_ex_is_load,
  input  logic [4:0]              i_ex_rd_id,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_pc,
  output alu_opcode_t             o_alu_opcode,
  output logic [XLEN-1:0]         o_alu_op1,
  output logic [XLEN-1:0]         o_alu_op2,
  output logic [4:0]              o_rd_id,
  output logic                    o_is_reg_write,
  output logic                    o_is_load,
  output logic                    o_is_store,
  output logic [2:0]              o_mem_size,
  output logic                    o_is_jump,
  output logic [XLEN-1:0]         o_jump_address,
  output logic                    o_is_branch,
  output logic [2:0]              o_branch_type,
  output logic [XLEN-1:0]         o_store_data,
  output logic                    o_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode   = i_instruction[6:0];
  assign rd       = i_instruction[11:7];
  assign funct3   = i_instruction[14:12];
  assign o_rs1_id = i_instruction[19:15];
  assign o_rs2_id = i_instruction[24:20];
  assign funct7   = i_instruction[31:25];

  assign imm_i = XLEN'($signed(i_instruction[31:20]));
  assign imm_s = XLEN'($signed({i_instruction[31:25], i_instruction[11:7]}));
  assign imm_b = XLEN'($signed({i_instruction[31], i_instruction[7], i_instruction[30:25],
                                i_instruction[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i_instruction[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i_instruction[31], i_instruction[19:12], i_instruction[20],
                                i_instruction[30:21], 1'b0}));

  // x0 reads as zero; otherwise the youngest matching forwarding source wins over the regfile.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] id,
                                              input logic [XLEN-1:0] rf_data,
                                              input logic [NUM_FWD-1:0] fv,
                                              input logic [NUM_FWD*5-1:0] frd,
                                              input logic [NUM_FWD*XLEN-1:0] fdata);
    logic [XLEN-1:0] v;
    v = rf_data;
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (fv[k] && (frd[k*5 +: 5] == id)) v = fdata[k*XLEN +: XLEN];
    end
    if (id == 5'd0) v = '0;
    return v;
  endfunction

  // Base integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_opcode_t base_alu(input logic [2:0] f3, input logic alt);
    alu_opcode_t r;
    case (f3)
      3'd0:    if (alt) r = ALU_SUB; else r = ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    if (alt) r = ALU_SRA; else r = ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  assign rs1_val = resolve(o_rs1_id, i_rs1_data, i_fwd_valid, i_fwd_rd_id, i_fwd_data);
  assign rs2_val = resolve(o_rs2_id, i_rs2_data, i_fwd_valid, i_fwd_rd_id, i_fwd_data);

  alu_opcode_t     alu_c;
  logic [XLEN-1:0] op1_c, op2_c, jaddr_c;
  logic [4:0]      rd_c;
  logic [2:0]      msize_c, btype_c;
  logic            use_rs1_c, use_rs2_c, illegal_c;
  logic            wr_c, ld_c, st_c, jmp_c, br_c;
  logic            hazard_c, fire_in_c;

  // Instruction decode: operand map, control flags, legality, register usage.
  always_comb begin
    alu_c     = ALU_ADD;
    op1_c     = '0;
    op2_c     = '0;
    jaddr_c   = '0;
    rd_c      = 5'd0;
    msize_c   = 3'd0;
    btype_c   = 3'd0;
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    illegal_c = 1'b0;
    wr_c      = 1'b0;
    ld_c      = 1'b0;
    st_c      = 1'b0;
    jmp_c     = 1'b0;
    br_c      = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1_c = 1'b1; use_rs2_c = 1'b1;
        op1_c = rs1_val; op2_c = rs2_val; rd_c = rd; wr_c = 1'b1;
        if (funct7 == 7'b0000000) begin
          alu_c = base_alu(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          alu_c = base_alu(funct3, 1'b1);
        end else if (funct7 == 7'b0000001 && ENABLE_M) begin
          case (funct3)
            3'd0:    alu_c = ALU_MUL;
            3'd1:    alu_c = ALU_MULH;
            3'd2:    alu_c = ALU_MULHSU;
            3'd3:    alu_c = ALU_MULHU;
            3'd4:    alu_c = ALU_DIV;
            3'd5:    alu_c = ALU_DIVU;
            3'd6:    alu_c = ALU_REM;
            default: alu_c = ALU_REMU;
          endcase
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        use_rs1_c = 1'b1;
        op1_c = rs1_val; op2_c = imm_i; rd_c = rd; wr_c = 1'b1;
        alu_c = base_alu(funct3, (funct3 == 3'd5) && i_instruction[30]);
        if (funct3 == 3'd1) illegal_c = (funct7 != 7'b0000000);
        if (funct3 == 3'd5) illegal_c = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_LOAD: begin
        use_rs1_c = 1'b1;
        op1_c = rs1_val; op2_c = imm_i; rd_c = rd; wr_c = 1'b1; ld_c = 1'b1;
        msize_c = funct3;
        illegal_c = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        use_rs1_c = 1'b1; use_rs2_c = 1'b1;
        op1_c = rs1_val; op2_c = imm_s; st_c = 1'b1;
        msize_c = funct3;
        illegal_c = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        // SUB lets execute derive the compare from the ALU when it wants to.
        use_rs1_c = 1'b1; use_rs2_c = 1'b1;
        op1_c = rs1_val; op2_c = rs2_val; alu_c = ALU_SUB; br_c = 1'b1;
        btype_c = funct3; jaddr_c = i_pc + imm_b;
        illegal_c = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        op1_c = i_pc; op2_c = XLEN'(4); rd_c = rd; wr_c = 1'b1; jmp_c = 1'b1;
        jaddr_c = i_pc + imm_j;
      end
      OPC_JALR: begin
        use_rs1_c = 1'b1;
        op1_c = i_pc; op2_c = XLEN'(4); rd_c = rd; wr_c = 1'b1; jmp_c = 1'b1;
        jaddr_c = (rs1_val + imm_i) & ~XLEN'(1);
        illegal_c = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        op2_c = imm_u; rd_c = rd; wr_c = 1'b1;
      end
      OPC_AUIPC: begin
        op1_c = i_pc; op2_c = imm_u; rd_c = rd; wr_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
    if (illegal_c) begin
      wr_c = 1'b0; ld_c = 1'b0; st_c = 1'b0; jmp_c = 1'b0; br_c = 1'b0;
    end else if (rd_c == 5'd0) begin
      wr_c = 1'b0;
    end
  end

  // Load-use hazard and input handshake.
  always_comb begin
    hazard_c  = i_ex_is_load && (i_ex_rd_id != 5'd0) && i_valid &&
                ((use_rs1_c && (o_rs1_id == i_ex_rd_id)) ||
                 (use_rs2_c && (o_rs2_id == i_ex_rd_id)));
    o_ready   = !hazard_c && (!o_valid || i_ready);
    fire_in_c = i_valid && o_ready;
  end

  // Stage register: flush wins, then accept, then drain/bubble, else hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid        <= 1'b0;
      o_pc           <= '0;
      o_alu_opcode   <= ALU_ADD;
      o_alu_op1      <= '0;
      o_alu_op2      <= '0;
      o_rd_id        <= 5'd0;
      o_is_reg_write <= 1'b0;
      o_is_load      <= 1'b0;
      o_is_store     <= 1'b0;
      o_mem_size     <= 3'd0;
      o_is_jump      <= 1'b0;
      o_jump_address <= '0;
      o_is_branch    <= 1'b0;
      o_branch_type  <= 3'd0;
      o_store_data   <= '0;
      o_illegal      <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (fire_in_c) begin
      o_valid        <= 1'b1;
      o_pc           <= i_pc;
      o_alu_opcode   <= alu_c;
      o_alu_op1      <= op1_c;
      o_alu_op2      <= op2_c;
      o_rd_id        <= rd_c;
      o_is_reg_write <= wr_c;
      o_is_load      <= ld_c;
      o_is_store     <= st_c;
      o_mem_size     <= msize_c;
      o_is_jump      <= jmp_c;
      o_jump_address <= jaddr_c;
      o_is_branch    <= br_c;
      o_branch_type  <= btype_c;
      o_store_data   <= rs2_val;
      o_illegal      <= illegal_c;
    end else if (!o_valid || i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic checked against a behavioural decode model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        st;
    logic [2:0]  ms;
    logic        jmp;
    logic [31:0] jaddr;
    logic        br;
    logic [2:0]  bt;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_pc = '0;
  logic [31:0] i_instruction = '0;
  logic [4:0]  o_rs1_id, o_rs2_id;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [1:0]  i_fwd_valid = '0;
  logic [9:0]  i_fwd_rd_id = '0;
  logic [63:0] i_fwd_data = '0;
  logic        i_ex_is_load = 1'b0;
  logic [4:0]  i_ex_rd_id = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_pc, o_alu_op1, o_alu_op2, o_jump_address, o_store_data;
  alu_opcode_t o_alu_opcode;
  logic [4:0]  o_rd_id;
  logic        o_is_reg_write, o_is_load, o_is_store, o_is_jump, o_is_branch, o_illegal;
  logic [2:0]  o_mem_size, o_branch_type;

  logic [31:0] rf [32];
  exp_t        got;
  int          total = 0;
  int          bad = 0;

  decode_stage #(.XLEN(32), .NUM_FWD(2), .ENABLE_M(1'b0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_instruction(i_instruction), .o_rs1_id(o_rs1_id), .o_rs2_id(o_rs2_id),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_fwd_valid(i_fwd_valid),
    .i_fwd_rd_id(i_fwd_rd_id), .i_fwd_data(i_fwd_data), .i_ex_is_load(i_ex_is_load),
    .i_ex_rd_id(i_ex_rd_id), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_alu_opcode(o_alu_opcode), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
    .o_rd_id(o_rd_id), .o_is_reg_write(o_is_reg_write), .o_is_load(o_is_load),
    .o_is_store(o_is_store), .o_mem_size(o_mem_size), .o_is_jump(o_is_jump),
    .o_jump_address(o_jump_address), .o_is_branch(o_is_branch),
    .o_branch_type(o_branch_type), .o_store_data(o_store_data), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // Register file model driven from the DUT's read addresses.
  assign i_rs1_data = rf[o_rs1_id];
  assign i_rs2_data = rf[o_rs2_id];

  always_comb begin
    got.pc = o_pc; got.alu = 5'(o_alu_opcode); got.op1 = o_alu_op1; got.op2 = o_alu_op2;
    got.rd = o_rd_id; got.wr = o_is_reg_write; got.ld = o_is_load; got.st = o_is_store;
    got.ms = o_mem_size; got.jmp = o_is_jump; got.jaddr = o_jump_address;
    got.br = o_is_branch; got.bt = o_branch_type; got.sd = o_store_data; got.ill = o_illegal;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Operand value as the architecture defines it: x0 is zero, youngest forward wins.
  function automatic logic [31:0] res(input logic [4:0] id, input logic [31:0] rfv,
                                      input logic [1:0] fv, input logic [9:0] frd,
                                      input logic [63:0] fd);
    if (id == 5'd0) return 32'd0;
    for (int k = 0; k < 2; k++) if (fv[k] && frd[k*5 +: 5] == id) return fd[k*32 +: 32];
    return rfv;
  endfunction

  // {uses rs2, uses rs1} by opcode.
  function automatic logic [1:0] uses(input logic [6:0] opc);
    case (opc)
      7'h33, 7'h63, 7'h23: return 2'b11;
      7'h13, 7'h03, 7'h67: return 2'b01;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] ins,
                                        input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [4:0] tbl [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] ii, is_, ib, ij, iu;
    tbl = '{5'(ALU_ADD), 5'(ALU_SLL), 5'(ALU_SLT), 5'(ALU_SLTU),
            5'(ALU_XOR), 5'(ALU_SRL), 5'(ALU_OR), 5'(ALU_AND)};
    e = '0;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ii  = 32'($signed(ins) >>> 20);
    is_ = {ii[31:5], ins[11:7]};
    ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    iu  = {ins[31:12], 12'h000};
    e.pc = pc; e.sd = b; e.alu = 5'(ALU_ADD);
    case (opc)
      7'h33: begin
        e.op1 = a; e.op2 = b; e.rd = ins[11:7]; e.wr = 1'b1;
        if (f7 == 7'h00) e.alu = tbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'(ALU_SUB);
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'(ALU_SRA);
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.op1 = a; e.op2 = ii; e.rd = ins[11:7]; e.wr = 1'b1; e.alu = tbl[f3];
        if (f3 == 3'd1) e.ill = (f7 != 7'h00);
        if (f3 == 3'd5) begin
          e.ill = !(f7 == 7'h00 || f7 == 7'h20);
          if (f7 == 7'h20) e.alu = 5'(ALU_SRA);
        end
      end
      7'h03: begin
        e.op1 = a; e.op2 = ii; e.rd = ins[11:7]; e.wr = 1'b1; e.ld = 1'b1; e.ms = f3;
        e.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'h23: begin
        e.op1 = a; e.op2 = is_; e.st = 1'b1; e.ms = f3; e.ill = (f3 > 3'd2);
      end
      7'h63: begin
        e.op1 = a; e.op2 = b; e.alu = 5'(ALU_SUB); e.br = 1'b1; e.bt = f3;
        e.jaddr = pc + ib; e.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6F: begin
        e.op1 = pc; e.op2 = 32'd4; e.rd = ins[11:7]; e.wr = 1'b1; e.jmp = 1'b1;
        e.jaddr = pc + ij;
      end
      7'h67: begin
        e.op1 = pc; e.op2 = 32'd4; e.rd = ins[11:7]; e.wr = 1'b1; e.jmp = 1'b1;
        e.jaddr = (a + ii) & 32'hFFFF_FFFE; e.ill = (f3 != 3'd0);
      end
      7'h37: begin e.op2 = iu; e.rd = ins[11:7]; e.wr = 1'b1; end
      7'h17: begin e.op1 = pc; e.op2 = iu; e.rd = ins[11:7]; e.wr = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill || e.rd == 5'd0) e.wr = 1'b0;
    if (e.ill) begin e.ld = 1'b0; e.st = 1'b0; e.jmp = 1'b0; e.br = 1'b0; end
    return e;
  endfunction

  // Random instruction biased toward x0..x7 so forwarding and hazards collide often.
  function automatic logic [31:0] gen_instr();
    logic [4:0] r1, r2, rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] rnd;
    r1 = 5'($urandom % 8); r2 = 5'($urandom % 8); rd = 5'($urandom % 8);
    f3 = 3'($urandom); rnd = $urandom;
    case ($urandom % 12)
      0: begin
        f7 = ($urandom % 2 != 0) ? 7'h00 : 7'h20;
        if (f7 == 7'h20) f3 = ($urandom % 2 != 0) ? 3'd0 : 3'd5;
        return {f7, r2, r1, f3, rd, 7'h33};
      end
      1: return {rnd[6:0], r2, r1, f3, rd, 7'h33};
      2: begin
        f7 = ($urandom % 3 == 0) ? rnd[6:0] : (($urandom % 2 != 0) ? 7'h00 : 7'h20);
        return {f7, rnd[11:7], r1, f3, rd, 7'h13};
      end
      3:  return {rnd[11:0], r1, f3, rd, 7'h03};
      4:  return {rnd[6:0], r2, r1, f3, rnd[11:7], 7'h23};
      5:  return {rnd[6:0], r2, r1, f3, rnd[11:7], 7'h63};
      6:  return {rnd[19:0], rd, 7'h6F};
      7:  return {rnd[11:0], r1, ($urandom % 4 == 0) ? f3 : 3'd0, rd, 7'h67};
      8:  return {rnd[19:0], rd, 7'h37};
      9:  return {rnd[19:0], rd, 7'h17};
      10: return {7'h01, r2, r1, f3, rd, 7'h33};
      default: return rnd;
    endcase
  endfunction

  task automatic idle();
    i_valid = 1'b0; i_flush = 1'b0; i_ex_is_load = 1'b0; i_ex_rd_id = '0;
    i_fwd_valid = '0; i_ready = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    idle();
    i_rst = 1'b1;
    tick(); tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (got !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", got); end
    i_rst = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_addi();
    rf[1] = 32'd15;
    i_pc = 32'd4; i_instruction = 32'h0050_8193; i_valid = 1'b1;
    #1;
    total++; if (o_rs1_id !== 5'd1) begin bad++; $display("FAIL addi_rs1_id got=%0d exp=1", o_rs1_id); end
    tick();
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", o_valid); end
    total++; if (o_alu_op1 !== 32'd15) begin bad++; $display("FAIL addi_op1 got=%h exp=f", o_alu_op1); end
    total++; if (o_alu_op2 !== 32'd5) begin bad++; $display("FAIL addi_op2 got=%h exp=5", o_alu_op2); end
    total++; if (o_rd_id !== 5'd3 || o_is_reg_write !== 1'b1)
      begin bad++; $display("FAIL addi_rd got=%0d/%b exp=3/1", o_rd_id, o_is_reg_write); end
    total++; if (o_pc !== 32'd4) begin bad++; $display("FAIL addi_pc got=%h exp=4", o_pc); end
  endtask

  task automatic test_forwarding();
    rf[2] = 32'd5;
    i_pc = 32'd8; i_instruction = 32'hFF01_0113; i_valid = 1'b1;
    i_fwd_valid = 2'b11; i_fwd_rd_id = {5'd2, 5'd2}; i_fwd_data = {32'h0000_DEAD, 32'h0000_0100};
    tick();
    total++; if (o_alu_op1 !== 32'h100) begin bad++; $display("FAIL fwd_youngest got=%h exp=100", o_alu_op1); end
    total++; if (o_alu_op2 !== 32'hFFFF_FFF0) begin bad++; $display("FAIL fwd_imm got=%h exp=fffffff0", o_alu_op2); end
    i_fwd_valid = 2'b10;
    tick();
    total++; if (o_alu_op1 !== 32'hDEAD) begin bad++; $display("FAIL fwd_older got=%h exp=dead", o_alu_op1); end
    i_fwd_valid = 2'b00;
    tick();
    total++; if (o_alu_op1 !== 32'd5) begin bad++; $display("FAIL fwd_regfile got=%h exp=5", o_alu_op1); end
    rf[0] = 32'h1234_5678;
    i_instruction = 32'h0050_0193; i_fwd_valid = 2'b11; i_fwd_rd_id = '0;
    tick();
    total++; if (o_alu_op1 !== 32'd0) begin bad++; $display("FAIL fwd_x0 got=%h exp=0", o_alu_op1); end
    rf[0] = 32'd0;
    idle();
  endtask

  task automatic test_load_use();
    rf[1] = 32'd7; rf[2] = 32'd9;
    i_ex_is_load = 1'b1; i_ex_rd_id = 5'd2;
    i_pc = 32'h20; i_instruction = 32'h0020_81B3; i_valid = 1'b1;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b exp=0", o_ready); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", o_valid); end
    i_ex_is_load = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL lu_release got=%b exp=1", o_ready); end
    tick();
    total++; if (o_valid !== 1'b1 || o_alu_op2 !== 32'd9 || o_alu_op1 !== 32'd7)
      begin bad++; $display("FAIL lu_accept got=%b/%h/%h exp=1/7/9", o_valid, o_alu_op1, o_alu_op2); end
    i_ex_is_load = 1'b1; i_ex_rd_id = 5'd0;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL lu_x0 got=%b exp=1", o_ready); end
    i_ex_rd_id = 5'd2; i_instruction = 32'h1234_5137;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL lu_lui got=%b exp=1", o_ready); end
    idle();
  endtask

  task automatic test_jalr();
    rf[1] = 32'd500;
    i_pc = 32'h18; i_instruction = 32'h0040_8167; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    total++; if (o_is_jump !== 1'b1 || o_jump_address !== 32'h1F8)
      begin bad++; $display("FAIL jalr_target got=%b/%h exp=1/1f8", o_is_jump, o_jump_address); end
    total++; if (o_alu_op1 !== 32'h18 || o_alu_op2 !== 32'd4 || o_rd_id !== 5'd2)
      begin bad++; $display("FAIL jalr_ops got=%h/%h/%0d exp=18/4/2", o_alu_op1, o_alu_op2, o_rd_id); end
  endtask

  task automatic test_hold_flush();
    rf[1] = 32'd15;
    i_pc = 32'h40; i_instruction = 32'h0050_8193; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_ready = 1'b0; i_pc = 32'h44; i_instruction = 32'h1234_50B7;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL hold_ready c=%0d got=%b exp=0", c, o_ready); end
      tick();
      total++; if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_alu_op1 !== 32'd15 || o_alu_op2 !== 32'd5 || o_rd_id !== 5'd3)
        begin bad++; $display("FAIL hold_stable c=%0d got=%b/%h/%h/%h exp=1/40/f/5", c, o_valid, o_pc, o_alu_op1, o_alu_op2); end
    end
    i_flush = 1'b1;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", o_ready); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
    i_flush = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_after got=%b exp=1", o_ready); end
    idle();
    tick();
  endtask

  task automatic test_illegal_reset();
    i_pc = 32'h80; i_instruction = 32'h0000_007F; i_valid = 1'b1;
    tick();
    total++; if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_is_reg_write !== 1'b0)
      begin bad++; $display("FAIL ill_opcode got=%b/%b/%b exp=1/1/0", o_valid, o_illegal, o_is_reg_write); end
    i_instruction = 32'h0220_8133;
    tick();
    i_valid = 1'b0; i_ready = 1'b0;
    total++; if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_is_reg_write !== 1'b0)
      begin bad++; $display("FAIL ill_mul got=%b/%b/%b exp=1/1/0", o_valid, o_illegal, o_is_reg_write); end
    #2 i_rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0 || got !== '0)
      begin bad++; $display("FAIL async_reset got=%b/%h exp=0/0", o_valid, got); end
    tick();
    i_rst = 1'b0;
    idle();
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b exp=0", o_valid); end
  endtask

  task automatic test_random();
    logic        mvalid;
    exp_t        mexp;
    logic [31:0] a, b;
    logic [1:0]  u;
    logic        hz, er;
    mexp = '0;
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    mvalid = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int c = 0; c < 500; c++) begin
      i_valid = ($urandom % 4) != 0;
      i_instruction = gen_instr();
      i_pc = $urandom & 32'hFFFF_FFFC;
      i_ready = ($urandom % 4) != 0;
      i_fwd_valid = 2'($urandom);
      i_fwd_rd_id = {5'($urandom % 8), 5'($urandom % 8)};
      i_fwd_data = {$urandom, $urandom};
      i_ex_is_load = ($urandom % 3) == 0;
      i_ex_rd_id = 5'($urandom % 8);
      i_flush = ($urandom % 16) == 0;
      #1;
      a = res(i_instruction[19:15], rf[i_instruction[19:15]], i_fwd_valid, i_fwd_rd_id, i_fwd_data);
      b = res(i_instruction[24:20], rf[i_instruction[24:20]], i_fwd_valid, i_fwd_rd_id, i_fwd_data);
      u = uses(i_instruction[6:0]);
      hz = i_ex_is_load && i_ex_rd_id != 5'd0 && i_valid &&
           ((u[0] && i_instruction[19:15] == i_ex_rd_id) || (u[1] && i_instruction[24:20] == i_ex_rd_id));
      er = !hz && (!mvalid || i_ready);
      total++; if (o_ready !== er) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, o_ready, er); end
      if (i_flush) mvalid = 1'b0;
      else if (i_valid && er) begin mvalid = 1'b1; mexp = model_decode(i_pc, i_instruction, a, b); end
      else if (!mvalid || i_ready) mvalid = 1'b0;
      tick();
      total++; if (o_valid !== mvalid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, o_valid, mvalid); end
      if (mvalid) begin
        total++;
        if (mexp.ill) begin
          if ({got.ill, got.wr, got.ld, got.st, got.jmp, got.br} !== {mexp.ill, mexp.wr, mexp.ld, mexp.st, mexp.jmp, mexp.br})
            begin bad++; $display("FAIL rand_illegal cyc=%0d got=%h exp=%h", c, got, mexp); end
        end else if (got !== mexp) begin
          bad++; $display("FAIL rand_fields cyc=%0d ins=%h got=%h exp=%h", c, i_instruction, got, mexp);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forwarding();
    test_load_use();
    test_jalr();
    test_hold_flush();
    test_illegal_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
